display_scan_mux: RTL and testbench

//  Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment bus. Each

---
 rtl/display_pkg.sv | 17 +
 rtl/display_scan_mux_checker.sv | 19 +
 rtl/display_scan_mux_scan_timer.sv | 78 +++++++
 rtl/display_scan_mux.sv | 109 ++++++++++
 tb/tb_display_scan_mux.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
package display_pkg;

  localparam int DEF_NUM_DIGITS = 8;
  localparam int MAX_DIGITS = 16;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic AN_OFF = 1'b1;
  localparam logic AN_ON = 1'b0;

  // Callers zero-extend their packed digit bus to MAX_DIGITS nibbles.
  function automatic logic [3:0] digit_slice(input logic [4*MAX_DIGITS-1:0] bus,
                                             input logic [3:0] i);
    return bus[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/display_scan_mux_checker.sv
// Per-cycle safety properties on the anode/segment outputs.
module display_scan_mux_checker
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [NUM_DIGITS-1:0] an,
  input logic [3:0]            digit_x
);

  a_one_hot_anode: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(~an) <= 32'sd1);

  a_dark_is_blank: assert property (@(posedge clk) disable iff (!rst_n)
    (an == {NUM_DIGITS{AN_OFF}}) |-> (digit_x == BLANK_CODE));

endmodule

// File: rtl/display_scan_mux_scan_timer.sv
// Slot/digit scan counters plus the frame-start strobe and blink phase.
module scan_timer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SLOT_CYCLES = 12500,
  parameter int BLINK_FRAMES = 250,
  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int FW = $clog2(BLINK_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [SW-1:0] slot_cnt,
  output logic [IW-1:0] idx,
  output logic          frame_start,
  output logic          blink_on
);

  logic [SW-1:0] slot_cnt_r, slot_nxt_s;
  logic [IW-1:0] idx_r, idx_nxt_s;
  logic [FW-1:0] frame_cnt_r, frame_cnt_nxt_s;
  logic          phase_r, phase_nxt_s;
  logic          frame_start_s;

  // Counter and phase registers; everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r  <= '0;
      idx_r       <= '0;
      frame_cnt_r <= '0;
      phase_r     <= 1'b1;
    end else begin
      slot_cnt_r  <= slot_nxt_s;
      idx_r       <= idx_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      phase_r     <= phase_nxt_s;
    end
  end

  assign frame_start_s = en && (slot_cnt_r == '0) && (idx_r == '0);

  // Next-state for slot/digit counters and the blink frame counter.
  always_comb begin
    slot_nxt_s      = slot_cnt_r;
    idx_nxt_s       = idx_r;
    frame_cnt_nxt_s = frame_cnt_r;
    phase_nxt_s     = phase_r;
    if (en) begin
      if (slot_cnt_r == SW'(SLOT_CYCLES - 1)) begin
        slot_nxt_s = '0;
        idx_nxt_s  = (idx_r == IW'(NUM_DIGITS - 1)) ? '0 : idx_r + 1'b1;
      end else begin
        slot_nxt_s = slot_cnt_r + 1'b1;
      end
    end else begin
      slot_nxt_s = slot_cnt_r;
    end
    // The frame that completes a half-period hands over to the toggled phase.
    if (frame_start_s) begin
      if (frame_cnt_r == FW'(BLINK_FRAMES)) begin
        phase_nxt_s     = ~phase_r;
        frame_cnt_nxt_s = FW'(1);
      end else begin
        frame_cnt_nxt_s = frame_cnt_r + 1'b1;
      end
    end else begin
      frame_cnt_nxt_s = frame_cnt_r;
    end
  end

  assign slot_cnt    = slot_cnt_r;
  assign idx         = idx_r;
  assign frame_start = frame_start_s;
  assign blink_on    = phase_nxt_s;

endmodule

// File: rtl/display_scan_mux.sv
// Scans NUM_DIGITS BCD digits onto one 7-segment bus with ghost blanking,
// per-digit blink and a per-frame input snapshot.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SLOT_CYCLES = 12500,
  parameter int BLANK_CYCLES = 250,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              digit_x,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0]             slot_cnt_s;
  logic [IW-1:0]             idx_s;
  logic                      frame_start_s, blink_on_s, blank_s;
  logic [4*NUM_DIGITS-1:0]   snap_digits_r, cur_digits_s;
  logic [NUM_DIGITS-1:0]     snap_dp_r, snap_mask_r, cur_dp_s, cur_mask_s;
  logic [4*MAX_DIGITS-1:0]   digits_wide_s;
  logic [NUM_DIGITS-1:0]     an_d_s, an_r;
  logic [3:0]                x_d_s, x_r;
  logic                      dp_d_s, dp_r, ft_r;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .slot_cnt   (slot_cnt_s),
    .idx        (idx_s),
    .frame_start(frame_start_s),
    .blink_on   (blink_on_s)
  );

  // Frame snapshot of the external digit, dp and blink requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits_r <= '0;
      snap_dp_r     <= '0;
      snap_mask_r   <= '0;
    end else if (frame_start_s) begin
      snap_digits_r <= digits_bcd;
      snap_dp_r     <= dp_in;
      snap_mask_r   <= blink_mask;
    end
  end

  // The slot-0 decode happens on the capture edge, so it uses the values being captured.
  always_comb begin
    cur_digits_s = frame_start_s ? digits_bcd : snap_digits_r;
    cur_dp_s     = frame_start_s ? dp_in : snap_dp_r;
    cur_mask_s   = frame_start_s ? blink_mask : snap_mask_r;
    digits_wide_s = '0;
    digits_wide_s[4*NUM_DIGITS-1:0] = cur_digits_s;
  end

  // Output decode for the current slot position.
  always_comb begin
    an_d_s  = {NUM_DIGITS{AN_OFF}};
    x_d_s   = BLANK_CODE;
    dp_d_s  = 1'b1;
    blank_s = (slot_cnt_s < SW'(BLANK_CYCLES)) || (!blink_on_s && cur_mask_s[idx_s]);
    if (!en) begin
      an_d_s = {NUM_DIGITS{AN_OFF}};
    end else if (blank_s) begin
      an_d_s = {NUM_DIGITS{AN_OFF}};
    end else begin
      an_d_s[idx_s] = AN_ON;
      x_d_s         = digit_slice(digits_wide_s, 4'(idx_s));
      dp_d_s        = ~cur_dp_s[idx_s];
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r <= {NUM_DIGITS{AN_OFF}};
      x_r  <= BLANK_CODE;
      dp_r <= 1'b1;
      ft_r <= 1'b0;
    end else begin
      an_r <= an_d_s;
      x_r  <= x_d_s;
      dp_r <= dp_d_s;
      ft_r <= frame_start_s;
    end
  end

  assign an         = an_r;
  assign digit_x    = x_r;
  assign dp_n       = dp_r;
  assign frame_tick = ft_r;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench: the driver queues per-cycle expectations, the monitor checks them.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] digits = 16'h4321;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  digit_x;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_tick;

  typedef struct {
    logic [3:0] an;
    logic [3:0] x;
    logic       dp_n;
    logic       ft;
    string      name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  display_scan_mux #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (4),
    .BLANK_CYCLES(1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .digits_bcd(digits),
    .dp_in     (dp_in),
    .blink_mask(blink_mask),
    .digit_x   (digit_x),
    .an        (an),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  display_scan_mux_checker #(.NUM_DIGITS(4)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .an     (an),
    .digit_x(digit_x)
  );

  task automatic push_dark(input string name);
    exp_t e;
    e.an = 4'b1111; e.x = 4'hF; e.dp_n = 1'b1; e.ft = 1'b0; e.name = name;
    q.push_back(e);
  endtask

  // One scan position p (slot = p/4, cycle-in-slot = p%4; cycle 0 is ghost blank).
  task automatic push_pos(input logic [15:0] dig, input logic [3:0] dp,
                          input logic [3:0] lit, input int p, input string name);
    exp_t e;
    int   s;
    s = p / 4;
    e.ft = (p == 0);
    e.name = $sformatf("%s.p%0d", name, p);
    if ((p % 4) == 0 || !lit[s]) begin
      e.an = 4'b1111; e.x = 4'hF; e.dp_n = 1'b1;
    end else begin
      e.an = 4'b1111;
      e.an[s] = 1'b0;
      e.x = dig[4*s +: 4];
      e.dp_n = ~dp[s];
    end
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [15:0] dig, input logic [3:0] dp,
                            input logic [3:0] lit, input string name);
    for (int p = 0; p < 16; p++) push_pos(dig, dp, lit, p, name);
  endtask

  // Monitor: compare on every clock edge and on asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if (an !== e.an || digit_x !== e.x || dp_n !== e.dp_n || frame_tick !== e.ft) begin
          miscompares++;
          $display("FAIL %s: got an=%b x=%h dp_n=%b ft=%b, want an=%b x=%h dp_n=%b ft=%b",
                   e.name, an, digit_x, dp_n, frame_tick, e.an, e.x, e.dp_n, e.ft);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", q.size());
    $fatal(1);
  end

  // Driver: n<k> below is the falling edge after the k-th clock edge since reset release.
  initial begin
    int wait_cnt;
    @(negedge clk);
    push_dark("reset");
    @(negedge clk);                                   // n0
    rst_n = 1'b1;
    push_frame(16'h4321, 4'b0000, 4'b1111, "f0");
    @(negedge clk);                                   // n1: frame_tick cycle
    digits = 16'h9876;
    push_frame(16'h9876, 4'b0000, 4'b1111, "f1");
    repeat (16) @(negedge clk);                       // n17
    blink_mask = 4'b0010;
    dp_in = 4'b0100;
    push_frame(16'h9876, 4'b0100, 4'b1101, "f2");
    push_frame(16'h9876, 4'b0100, 4'b1101, "f3");
    push_frame(16'h9876, 4'b0100, 4'b1111, "f4");
    push_frame(16'h9876, 4'b0100, 4'b1111, "f5");
    repeat (64) @(negedge clk);                       // n81
    blink_mask = 4'b0000;
    dp_in = 4'b0000;
    for (int p = 0; p < 10; p++) push_pos(16'h9876, 4'b0000, 4'b1111, p, "f6");
    for (int k = 0; k < 10; k++) push_dark("en_off");
    for (int p = 10; p < 16; p++) push_pos(16'h9876, 4'b0000, 4'b1111, p, "f6");
    repeat (25) @(negedge clk);                       // n106: mid slot 2
    en = 1'b0;
    repeat (10) @(negedge clk);                       // n116
    en = 1'b1;
    for (int p = 0; p < 14; p++) push_pos(16'h9876, 4'b0000, 4'b1111, p, "f7");
    repeat (20) @(negedge clk);                       // n136: mid slot 3
    push_dark("rst_async");
    push_dark("rst_hold");
    push_dark("rst_hold");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    digits = 16'hC0A5;
    rst_n = 1'b1;
    push_frame(16'hC0A5, 4'b0000, 4'b1111, "f8");
    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
